// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared FSM encoding and default constants for the UART receiver
// Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int C_DATA_BIT_DEFAULT = 8;
   localparam int C_SB_TICK_DEFAULT  = 16;
   localparam int C_DVSR_DEFAULT     = 27;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ============================================================================
// Module      : baud_tick_gen
// Description : Free-running divider producing a one-clk oversample tick
// Revision    : 1.0
// ============================================================================
`default_nettype none

module baud_tick_gen
   import uart_pkg::*;
#(
   parameter int DVSR = C_DVSR_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);

   localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(DVSR - 1)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick = (cnt_q == CW'(DVSR - 1));

endmodule

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// ============================================================================
// Module      : uart_byte_rx
// Description : 16x oversampling UART byte receiver; define UART_RX_PARITY_EN
//               to add an even-parity bit between data and stop.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int DATA_BIT = C_DATA_BIT_DEFAULT,
   parameter int SB_TICK  = C_SB_TICK_DEFAULT,
   parameter int DVSR     = C_DVSR_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_rx,
   output logic [DATA_BIT-1:0] o_data,
   output logic                o_rx_done_tick,
   output logic                o_frame_err,
   output logic                o_parity_err
);

   localparam int NW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

   logic [1:0]          sync_q;
   logic                rx_sync;
   logic                tick;
   state_t              state_q, state_d;
   logic [3:0]          s_cnt_q, s_cnt_d;
   logic [NW-1:0]       n_q, n_d;
   logic [DATA_BIT-1:0] b_q, b_d, data_q, data_d;
   logic                done_q, done_d;
   logic                ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                perr_q, perr_d;
   logic                par_bad_q, par_bad_d;
`endif

   baud_tick_gen #(.DVSR(DVSR)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .o_tick (tick)
   );

   assign rx_sync = sync_q[1];

   always_comb begin
      state_d = state_q;
      s_cnt_d = s_cnt_q;
      n_d     = n_q;
      b_d     = b_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d    = 1'b0;
      par_bad_d = par_bad_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!rx_sync) begin
               state_d = S_START;
               s_cnt_d = '0;
            end
         end
         S_START: begin
            // Half a bit in: a line that has risen again was only a glitch
            if (tick) begin
               if (s_cnt_q == 4'd7) begin
                  if (!rx_sync) begin
                     state_d = S_DATA;
                     s_cnt_d = '0;
                     n_d     = '0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (s_cnt_q == 4'd15) begin
                  s_cnt_d = '0;
                  b_d     = {rx_sync, b_q[DATA_BIT-1:1]};
                  if (n_q == NW'(DATA_BIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               if (s_cnt_q == 4'd15) begin
                  s_cnt_d   = '0;
                  par_bad_d = rx_sync ^ (^b_q);
                  state_d   = S_STOP;
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (s_cnt_q == 4'(SB_TICK - 1)) begin
                  // A low stop bit wins over any parity verdict
                  if (!rx_sync) begin
                     ferr_d  = 1'b1;
                     state_d = S_WAIT_HIGH;
                  end else begin
                     state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                     if (par_bad_q) begin
                        perr_d = 1'b1;
                     end else begin
                        done_d = 1'b1;
                        data_d = b_q;
                     end
`else
                     done_d = 1'b1;
                     data_d = b_q;
`endif
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 4'd1;
               end
            end
         end
         S_WAIT_HIGH: begin
            if (rx_sync) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= 2'b11;
         state_q <= S_IDLE;
         s_cnt_q <= '0;
         n_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         sync_q  <= {sync_q[0], i_rx};
         state_q <= state_d;
         s_cnt_q <= s_cnt_d;
         n_q     <= n_d;
         b_q     <= b_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q    <= perr_d;
         par_bad_q <= par_bad_d;
`endif
      end
   end

   assign o_data         = data_q;
   assign o_rx_done_tick = done_q;
   assign o_frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign o_parity_err   = perr_q;
`else
   assign o_parity_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
// ============================================================================
// Module      : tb_uart_byte_rx
// Description : Self-checking bench for uart_byte_rx against a frame-level model
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_byte_rx;

   localparam int DATA_BIT = 8;
   localparam int SB_TICK  = 16;
   localparam int DVSR     = 27;
   localparam int BIT_CLKS = 16 * DVSR;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       i_rx = 1'b1;
   logic [7:0] o_data;
   logic       o_rx_done_tick, o_frame_err, o_parity_err;

   uart_byte_rx #(.DATA_BIT(DATA_BIT), .SB_TICK(SB_TICK), .DVSR(DVSR)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_rx           (i_rx),
      .o_data         (o_data),
      .o_rx_done_tick (o_rx_done_tick),
      .o_frame_err    (o_frame_err),
      .o_parity_err   (o_parity_err)
   );

   always #5 clk = ~clk;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         ferr_seen = 0, perr_seen = 0, both_seen = 0, long_done = 0;
   int         ferr_exp  = 0, perr_exp  = 0;
   logic       prev_done = 1'b0;
   logic [7:0] last_good = 8'h00;

   always @(negedge clk) begin
      if (o_rx_done_tick) got_q.push_back(o_data);
      if (o_frame_err) ferr_seen <= ferr_seen + 1;
      if (o_parity_err) perr_seen <= perr_seen + 1;
      if (o_frame_err && o_parity_err) both_seen <= both_seen + 1;
      if (o_rx_done_tick && prev_done) long_done <= long_done + 1;
      prev_done <= o_rx_done_tick;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame and records what a correct receiver must report for it
   task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
      i_rx = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < DATA_BIT; i++) begin
         i_rx = d[i];
         wait_clks(BIT_CLKS);
      end
      if (PAR_EN) begin
         i_rx = par_v;
         wait_clks(BIT_CLKS);
      end
      i_rx = stop_v;
      wait_clks(BIT_CLKS);
      if (!stop_v) begin
         ferr_exp++;
      end else if (PAR_EN && (par_v != ^d)) begin
         perr_exp++;
      end else begin
         exp_q.push_back(d);
         last_good = d;
      end
   endtask

   task automatic check_scenario(input string tag);
      int n;
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
      chk({tag, "_frame_err"}, 32'(ferr_seen), 32'(ferr_exp));
      chk({tag, "_parity_err"}, 32'(perr_seen), 32'(perr_exp));
      chk({tag, "_err_overlap"}, 32'(both_seen), 32'd0);
      chk({tag, "_done_width"}, 32'(long_done), 32'd0);
      chk({tag, "_data_hold"}, 32'(o_data), 32'(last_good));
   endtask

   initial begin
      logic [7:0] d;
      logic       stop_v, par_v;
      int         glitch_len;

      rst = 1'b1;
      wait_clks(5);
      chk("reset_data", 32'(o_data), 32'd0);
      chk("reset_done", 32'(o_rx_done_tick), 32'd0);
      chk("reset_ferr", 32'(o_frame_err), 32'd0);
      chk("reset_perr", 32'(o_parity_err), 32'd0);
      rst = 1'b0;
      wait_clks(50);

      send_frame(8'hA5, 1'b1, ^8'hA5);
      wait_clks(20);
      check_scenario("single_a5");

      for (int i = 1; i <= 9; i++) begin
         d = 8'(i);
         send_frame(d, 1'b1, ^d);
      end
      wait_clks(20);
      check_scenario("back2back");

      glitch_len = 40 + int'($urandom % 120);
      i_rx = 1'b0;
      wait_clks(100);
      i_rx = 1'b1;
      wait_clks(BIT_CLKS);
      i_rx = 1'b0;
      wait_clks(glitch_len);
      i_rx = 1'b1;
      wait_clks(2 * BIT_CLKS);
      check_scenario("glitch");

      send_frame(8'h3C, 1'b0, ^8'h3C);
      wait_clks(2000);
      check_scenario("break_low");
      i_rx = 1'b1;
      wait_clks(BIT_CLKS);
      send_frame(8'h55, 1'b1, ^8'h55);
      wait_clks(20);
      check_scenario("after_break");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0);
      wait_clks(20);
      check_scenario("parity_bad");
      send_frame(8'h07, 1'b1, 1'b1);
      wait_clks(20);
      check_scenario("parity_good");
`endif

      // Abort 0xFF halfway through its fifth data bit
      i_rx = 1'b0;
      wait_clks(BIT_CLKS);
      i_rx = 1'b1;
      wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
      rst = 1'b1;
      last_good = 8'h00;
      wait_clks(4);
      rst = 1'b0;
      wait_clks(3 * BIT_CLKS);
      check_scenario("mid_reset");
      send_frame(8'h81, 1'b1, ^8'h81);
      wait_clks(20);
      check_scenario("post_reset");

      for (int k = 0; k < 3; k++) begin
         d      = 8'($urandom);
         stop_v = (($urandom % 4) != 0);
         par_v  = (^d) ^ (PAR_EN && (($urandom % 4) == 0));
         send_frame(d, stop_v, par_v);
         i_rx = 1'b1;
         wait_clks(stop_v ? int'($urandom % 200) : 50 + int'($urandom % 150));
      end
      wait_clks(20);
      check_scenario("random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 SHALL have parameter DATA_BIT, default 8: data bits per frame, LSB first.
REQ-002 SHALL have parameter SB_TICK, default 16: oversample ticks in the stop bit.
REQ-003 SHALL have parameter DVSR, default 27: clk cycles per oversample tick (clk / (16 x baud)).
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port o_data, output, DATA_BIT bits: last received byte, feeds the packet decoder's i_data.
REQ-008 SHALL have port o_rx_done_tick, output, 1 bit: one-clk pulse when o_data holds a new valid byte.
REQ-009 SHALL have port o_frame_err, output, 1 bit: one-clk pulse on a stop bit sampled low.
REQ-010 SHALL have port o_parity_err, output, 1 bit: one-clk pulse on a parity mismatch.

Function
REQ-011 SHALL pass i_rx through a 2-FF synchronizer; all sampling uses the synchronized value (2-clk latency).
REQ-012 SHALL generate an oversample tick, one clk wide, every DVSR clks; the counter runs freely, wraps DVSR-1 -> 0, and is never gated by state.
REQ-013 SHALL implement states S_IDLE, S_START, S_DATA, S_PARITY, S_STOP and S_WAIT_HIGH.
REQ-014 S_IDLE: a synchronized low SHALL move the FSM to S_START and clear the tick count s_cnt.
REQ-015 S_START: at s_cnt==7, a line still low SHALL move the FSM to S_DATA with s_cnt and bit count cleared; a line sampled high SHALL return the FSM to S_IDLE as a glitch, with no output pulse.
REQ-016 S_DATA: at s_cnt==15, the FSM SHALL clear s_cnt and right-shift the line into shift register bit DATA_BIT-1; after DATA_BIT bits it SHALL go to S_PARITY if parity is enabled, else to S_STOP.
REQ-017 S_STOP: at s_cnt==SB_TICK-1, the FSM SHALL sample the line.
REQ-018 Stop sample high with no parity error: SHALL load o_data, pulse o_rx_done_tick for exactly one clk, and go to S_IDLE.
REQ-019 Stop sample low: SHALL pulse o_frame_err, leave o_data unchanged, raise no done tick, and go to S_WAIT_HIGH.
REQ-020 S_WAIT_HIGH: SHALL go to S_IDLE only once the synchronized line is high (break protection).
REQ-021 Parity error with a valid stop bit: SHALL pulse o_parity_err, raise no done tick, leave o_data unchanged, and go to S_IDLE.
REQ-022 o_frame_err and o_parity_err SHALL never assert in the same cycle; a frame error takes precedence.
REQ-023 Back-to-back frames: a start edge arriving in the cycle S_IDLE is re-entered SHALL be accepted with no lost frame.
REQ-024 s_cnt SHALL be 4 bits, increment only on ticks, and wrap 15 -> 0.

Reset
REQ-025 rst SHALL force state S_IDLE; the synchronizer to all ones; o_data, the shift register, all counters and all pulse outputs to 0.
REQ-026 rst mid-frame SHALL abort the frame with no pulse; the next valid start edge after release SHALL be received normally.

Configuration
REQ-027 With UART_RX_PARITY_EN defined, S_PARITY SHALL sample one even-parity bit at s_cnt==15 and check it against the XOR of the data bits.
REQ-028 Without UART_RX_PARITY_EN, S_PARITY SHALL be unreachable, frames SHALL be 1+DATA_BIT+1 bits, and o_parity_err SHALL be tied 0.

Structure
REQ-029 State encodings and the default DVSR/SB_TICK constants SHALL live in the shared package uart_pkg.
REQ-030 The oversample tick generator SHALL be a sub-module named baud_tick_gen, with parameter DVSR and ports clk, rst and o_tick.

Verification
REQ-031 DVSR=27, no parity, send 0xA5 at 432 clk/bit -> exactly one o_rx_done_tick with o_data=0xA5, and no error pulse.
REQ-032 Send 9 back-to-back bytes 0x01..0x09 -> nine done ticks, bytes delivered in order, none lost.
REQ-033 Low glitch of 100 clks on an idle line -> FSM returns to S_IDLE, no pulses.
REQ-034 Byte 0x3C with stop bit forced low, line then held low 2000 clks -> one o_frame_err, no done tick, no re-trigger until the line goes high; next byte 0x55 received correctly.
REQ-035 UART_RX_PARITY_EN defined, 0x07 sent with parity bit 0 -> o_parity_err pulse, no done tick; sent with parity bit 1 -> done tick with o_data=0x07.
REQ-036 rst asserted during bit 4 of 0xFF -> no pulse; a following 0x81 is received with o_data=0x81.
